// File: rtl/fir_pkg.sv
// Shared constants, state encoding and coefficient-index-to-bank mapping for the
// FIR coefficient sequencer.
package fir_pkg;

    localparam int unsigned DW         = 16;
    localparam int unsigned AW         = 4;
    localparam int unsigned BANK_DEPTH = 10;
    localparam int unsigned MAX_COEFF  = 33;
    localparam int unsigned IW         = 6;
    localparam int unsigned NUM_BANK   = 4;

    localparam logic [IW-1:0] N_MAX    = IW'(MAX_COEFF);
    localparam logic [IW-1:0] LAST_IDX = IW'(MAX_COEFF - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        LOAD  = 2'd2,
        RUN   = 2'd3
    } state_e;

    typedef struct packed {
        logic [1:0]    bank;
        logic [AW-1:0] addr;
    } bank_addr_t;

    function automatic logic [1:0] idx_to_bank(input logic [IW-1:0] idx);
        logic [1:0] bank;
        if (idx >= IW'(3 * BANK_DEPTH)) begin
            bank = 2'd3;
        end else if (idx >= IW'(2 * BANK_DEPTH)) begin
            bank = 2'd2;
        end else if (idx >= IW'(BANK_DEPTH)) begin
            bank = 2'd1;
        end else begin
            bank = 2'd0;
        end
        return bank;
    endfunction

    function automatic bank_addr_t idx_to_bank_addr(input logic [IW-1:0] idx);
        bank_addr_t    ba;
        logic [IW-1:0] base;
        logic [IW-1:0] rem;
        ba.bank = idx_to_bank(idx);
        base    = IW'(ba.bank) * IW'(BANK_DEPTH);
        rem     = idx - base;
        ba.addr = rem[AW-1:0];
        return ba;
    endfunction

endpackage

// File: rtl/fir_bank_mux.sv
// Registered per-bank chip-select / write-strobe / address steering for one
// coefficient SRAM access per cycle, shared by host writes and readback.
module fir_bank_mux
    import fir_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid,
    input  logic                   wr,
    input  logic [IW-1:0]          idx,
    input  logic [DW-1:0]          data,
    output logic [NUM_BANK-1:0]    csn,
    output logic [NUM_BANK-1:0]    wrn,
    output logic [NUM_BANK*AW-1:0] addr,
    output logic [DW-1:0]          wdata
);

    bank_addr_t             ba;
    logic [NUM_BANK-1:0]    csn_d;
    logic [NUM_BANK-1:0]    wrn_d;
    logic [NUM_BANK*AW-1:0] addr_d;
    logic [DW-1:0]          wdata_d;

    assign ba = idx_to_bank_addr(idx);

    always_comb begin
        csn_d   = '1;
        wrn_d   = '1;
        addr_d  = '0;
        wdata_d = wdata;
        if (valid) begin
            csn_d[ba.bank]              = 1'b0;
            wrn_d[ba.bank]              = ~wr;
            addr_d[ba.bank*AW +: AW]    = ba.addr;
            if (wr) begin
                wdata_d = data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csn   <= '1;
            wrn   <= '1;
            addr  <= '0;
            wdata <= '0;
        end else begin
            csn   <= csn_d;
            wrn   <= wrn_d;
            addr  <= addr_d;
            wdata <= wdata_d;
        end
    end

endmodule

// File: rtl/fir_coeff_sequencer.sv
// Coefficient sequencer: steers host writes into the coefficient banks, then replays
// every tap into the coefficient registers in a fixed-length load before filtering.
module fir_coeff_sequencer
    import fir_pkg::*;
(
    input  logic                   iClk_12M,
    input  logic                   iRsn,
    input  logic                   iCoeffiUpdateFlag,
    input  logic                   iCsnRam,
    input  logic                   iWrnRam,
    input  logic [IW-1:0]          iAddrRam,
    input  logic [DW-1:0]          iWrDtRam,
    input  logic [IW-1:0]          iNumOfCoeff,
    input  logic [NUM_BANK*DW-1:0] iRdDtRam,
    output logic [NUM_BANK-1:0]    oCsnRam,
    output logic [NUM_BANK-1:0]    oWrnRam,
    output logic [NUM_BANK*AW-1:0] oAddrRam,
    output logic [DW-1:0]          oWrDtRam,
    output logic                   oCoeffWe,
    output logic [IW-1:0]          oCoeffIdx,
    output logic [DW-1:0]          oCoeffData,
    output logic [NUM_BANK-1:0]    oEnAcc,
    output logic                   oEnDelay,
    output logic                   oBusy
);

    logic                flag;
    state_e              state_q, state_d;
    logic [IW-1:0]       k_q, k_d;
    logic [IW-1:0]       nl_q, nl_d;
    logic                loaded_q, loaded_d;

    logic                req_valid;
    logic                req_wr;
    logic [IW-1:0]       req_idx;

    logic [1:0]          rd_bank;
    logic [DW-1:0]       rd_word;

    logic                coeff_we_q, coeff_we_d;
    logic [IW-1:0]       coeff_idx_q, coeff_idx_d;
    logic [DW-1:0]       coeff_data_q, coeff_data_d;
    logic [NUM_BANK-1:0] en_acc_q, en_acc_d;
    logic                en_delay_q, en_delay_d;
    logic                busy_q, busy_d;

    assign flag    = iCoeffiUpdateFlag;
    assign rd_bank = idx_to_bank(k_q);
    assign rd_word = iRdDtRam[rd_bank*DW +: DW];

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q  <= IDLE;
            k_q      <= '0;
            nl_q     <= '0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            nl_q     <= nl_d;
            loaded_q <= loaded_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        nl_d     = nl_q;
        loaded_d = loaded_q;
        unique case (state_q)
            IDLE: begin
                if (flag) begin
                    state_d = WRITE;
                end else if (loaded_q) begin
                    state_d = RUN;
                end
            end
            WRITE: begin
                if (!flag) begin
                    state_d = LOAD;
                    k_d     = '0;
                    nl_d    = (iNumOfCoeff > N_MAX) ? N_MAX : iNumOfCoeff;
                end
            end
            LOAD: begin
                // k_q == N_MAX is the trailing cycle that retires the write for the last tap
                if (flag) begin
                    state_d = WRITE;
                end else if (k_q == N_MAX) begin
                    state_d  = RUN;
                    loaded_d = 1'b1;
                end else begin
                    k_d = k_q + IW'(1);
                end
            end
            RUN: begin
                if (flag) begin
                    state_d = WRITE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Readback is issued from next-state values so bank data is present in LOAD cycle k.
    always_comb begin
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_idx   = iAddrRam;
        if (state_q == WRITE && flag && !iCsnRam && !iWrnRam && iAddrRam < N_MAX) begin
            req_valid = 1'b1;
            req_wr    = 1'b1;
        end else if (state_d == LOAD && k_d < nl_d) begin
            req_valid = 1'b1;
            req_idx   = k_d;
        end
    end

    always_comb begin
        coeff_we_d   = 1'b0;
        coeff_idx_d  = coeff_idx_q;
        coeff_data_d = coeff_data_q;
        if (state_q == LOAD && !flag && k_q <= LAST_IDX) begin
            coeff_we_d   = 1'b1;
            coeff_idx_d  = k_q;
            coeff_data_d = (k_q < nl_q) ? rd_word : '0;
        end
        busy_d     = (state_d == WRITE) || (state_d == LOAD);
        en_delay_d = (state_d == RUN);
        for (int unsigned b = 0; b < NUM_BANK; b++) begin
            en_acc_d[b] = (state_d == RUN) && (nl_q > IW'(BANK_DEPTH * b));
        end
    end

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            coeff_we_q   <= 1'b0;
            coeff_idx_q  <= '0;
            coeff_data_q <= '0;
            en_acc_q     <= '0;
            en_delay_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            coeff_we_q   <= coeff_we_d;
            coeff_idx_q  <= coeff_idx_d;
            coeff_data_q <= coeff_data_d;
            en_acc_q     <= en_acc_d;
            en_delay_q   <= en_delay_d;
            busy_q       <= busy_d;
        end
    end

    fir_bank_mux u_bank_mux (
        .clk   (iClk_12M),
        .rst_n (iRsn),
        .valid (req_valid),
        .wr    (req_wr),
        .idx   (req_idx),
        .data  (iWrDtRam),
        .csn   (oCsnRam),
        .wrn   (oWrnRam),
        .addr  (oAddrRam),
        .wdata (oWrDtRam)
    );

    assign oCoeffWe   = coeff_we_q;
    assign oCoeffIdx  = coeff_idx_q;
    assign oCoeffData = coeff_data_q;
    assign oEnAcc     = en_acc_q;
    assign oEnDelay   = en_delay_q;
    assign oBusy      = busy_q;

endmodule

// File: doc/fir_coeff_sequencer.md
Name: fir_coeff_sequencer

Overview:
Sequencer for the reconfigurable transposed FIR datapath. It routes host coefficient writes into the four single-port coefficient SRAM banks (10/10/10/3 words). After an update it reads every coefficient back into the tap coefficient registers, zero-filling unused taps. It then enables the MAC/shift stages for filtering. It replaces ad-hoc combinational coefficient capture with one explicit, cycle-deterministic load phase.

Parameters:
DW, 16, coefficient data width
AW, 4, SRAM bank address width
BANK_DEPTH, 10, words per bank (bank 3 uses 3)
MAX_COEFF, 33, total taps
IW, 6, coefficient index width

Ports:
iClk_12M  in  1  system clock
iRsn  in  1  asynchronous active-low reset
iCoeffiUpdateFlag  in  1  1 = host update window open
iCsnRam  in  1  host chip select, active low
iWrnRam  in  1  host write strobe, active low (0 = write)
iAddrRam  in  IW  host coefficient index 0..MAX_COEFF-1
iWrDtRam  in  DW  host write data (signed)
iNumOfCoeff  in  IW  active tap count N
iRdDtRam  in  4*DW  bank read data, bank b at bits [b*DW +: DW]
oCsnRam  out  4  per-bank chip select, active low
oWrnRam  out  4  per-bank write strobe, active low
oAddrRam  out  4*AW  per-bank address
oWrDtRam  out  DW  shared bank write data
oCoeffWe  out  1  coefficient register write pulse
oCoeffIdx  out  IW  coefficient register index
oCoeffData  out  DW  coefficient register data
oEnAcc  out  4  per-stage MAC enable
oEnDelay  out  1  delay-line enable
oBusy  out  1  high in WRITE or LOAD

Behaviour:
- All outputs are registered. On reset (async, iRsn=0), regardless of state:
  - oCsnRam=4'hF, oWrnRam=4'hF; oAddrRam, oWrDtRam, oCoeffWe, oCoeffIdx, oCoeffData, oEnAcc, oEnDelay, oBusy all 0.
  - State goes to IDLE; the index counter and latched N clear.
- Index map: bank = idx/10, addr = idx%10, computed combinationally.
- States: IDLE, WRITE, LOAD, RUN.
- IDLE:
  - Flag=1 -> WRITE.
  - Otherwise -> RUN only if a LOAD has completed since reset; else stay in IDLE.
- WRITE (oBusy=1):
  - A host cycle with iCsnRam=0, iWrnRam=0 and idx<33 writes one bank. On the next cycle the selected bank gets oCsnRam[b]=0, oWrnRam[b]=0 and its addr; oWrDtRam=data. Latency is 1 cycle.
  - Host cycles with idx>=33, or with iWrnRam=1, are dropped; all banks stay deselected.
  - Flag falling edge: latch Nl = min(iNumOfCoeff, 33), clear counter k, -> LOAD.
- LOAD (oBusy=1), fixed 34 cycles:
  - Cycle t=0..32: if t<Nl, issue a read on bank(t)/addr(t) (csn=0, wrn=1). Otherwise no bank is selected.
  - Cycle t+1: oCoeffWe=1, oCoeffIdx=t, oCoeffData = bank(t) read data if t<Nl, else 0.
  - After the write for idx 32 -> RUN.
  - Nl=0 loads all zeros.
- RUN (oBusy=0):
  - oEnDelay=1.
  - oEnAcc[b]=1 iff Nl > 10*b. Example: Nl=12 -> 4'b0011; Nl=33 -> 4'b1111.
- Flag rising in RUN or LOAD -> WRITE on the next cycle:
  - oEnAcc and oEnDelay drop to 0 in that cycle.
  - An aborted LOAD is discarded; stale registers may remain until the next full LOAD.
- Flag held high while a host write is in flight: the write completes normally.
- iNumOfCoeff changes outside the WRITE->LOAD edge are ignored.
- Flag high during reset release: IDLE -> WRITE on the first clock.

Decomposition:
- Shared package fir_pkg holds:
  - constants DW, AW, BANK_DEPTH, MAX_COEFF, NUM_BANK=4;
  - state encoding typedef (IDLE=0, WRITE=1, LOAD=2, RUN=3);
  - function idx_to_bank_addr.
- One sub-module is natural: fir_bank_mux. It performs the registered per-bank csn/wrn/addr/data steering from {valid, idx, wr, data} and is shared by the WRITE and LOAD paths.

Test Plan:
- Reset mid-LOAD (assert iRsn at t=10) -> all outputs at reset values within the same cycle; IDLE after release; no oCoeffWe.
- WRITE idx=15, data=16'h1234 -> next cycle oCsnRam=4'b1101, oWrnRam=4'b1101, bank1 addr=5, oWrDtRam=16'h1234. Idx=40 -> no bank selected.
- Write idx 0..32 with data=idx+1, N=12, drop flag:
  - oCoeffWe high for exactly 33 cycles, idx 0..32;
  - data = 1..12, then 0 for idx 12..32;
  - RUN with oEnAcc=4'b0011, oEnDelay=1.
- N=33 and N=45 (clamped) -> all 33 readbacks equal the written values; oEnAcc=4'b1111. N=0 -> all zeros; oEnAcc=4'b0000.
- Flag rising at LOAD t=20 -> WRITE next cycle; oCoeffWe stops; oEnAcc=0. Re-drop the flag -> full 34-cycle LOAD restarts from idx 0.
- Flag rising in RUN -> oEnAcc and oEnDelay go to 0 the next cycle; oBusy=1.
